// File: rtl/serial_add_sub.sv
// Bit-serial (or digit-serial) adder/subtractor: BITS_PER_CYCLE bits per clock,
// LSB group first, with carry, signed-overflow and zero flags on completion.
module serial_add_sub #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SUB,
  input  logic             CI,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             V,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned K     = BITS_PER_CYCLE;
  localparam int unsigned STEPS = (K == 0) ? 1 : WIDTH / K;
  localparam int unsigned CntW  = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (WIDTH < 2 || K < 1 || K > WIDTH || (WIDTH % K) != 0) begin : g_bad_params
    $error("serial_add_sub: BITS_PER_CYCLE must be in 1..WIDTH and divide WIDTH (WIDTH >= 2)");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDoneSt} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, y_q, y_d;
  logic             carry_q, carry_d, co_q, co_d, v_q, v_d, zero_q, zero_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [K:0]       c;
  logic [K-1:0]     gsum;
  logic [WIDTH-1:0] gsum_ext, sum_next;
  logic             last_step;

  // Ripple chain of full-adder cells over the current low-order group.
  always_comb begin
    c[0] = carry_q;
    gsum = '0;
    for (int i = 0; i < int'(K); i++) begin
      gsum[i]  = a_q[i] ^ b_q[i] ^ c[i];
      c[i + 1] = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
    end
  end

  // New group enters at the top so that after STEPS shifts sum_q is LSB-aligned.
  always_comb begin
    gsum_ext         = '0;
    gsum_ext[K-1:0]  = gsum;
    sum_next         = (sum_q >> K) | (gsum_ext << (WIDTH - K));
    last_step        = (cnt_q == CntW'(STEPS - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    co_d    = co_q;
    v_d     = v_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle, StDoneSt: begin
        state_d = StIdle;
        if (START) begin
          a_d     = A;
          b_d     = B ^ {WIDTH{SUB}};
          carry_d = CI ^ SUB;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> K;
        b_d     = b_q >> K;
        sum_d   = sum_next;
        carry_d = c[K];
        cnt_d   = cnt_q + CntW'(1);
        if (last_step) begin
          y_d     = sum_next;
          co_d    = c[K];
          v_d     = c[K] ^ c[K-1];
          zero_d  = (sum_next == '0);
          state_d = StDoneSt;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      y_q     <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      co_q    <= co_d;
      v_q     <= v_d;
      zero_q  <= zero_d;
    end
  end

  assign Y    = y_q;
  assign CO   = co_q;
  assign V    = v_q;
  assign ZERO = zero_q;
  assign BUSY = (state_q == StRun);
  assign DONE = (state_q == StDoneSt);

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: 8-bit/1-bit-per-cycle and 16-bit/4-bit-per-cycle instances,
// vector table plus scoreboard queues popped on each DONE pulse.
module tb_serial_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, sub8, ci8, co8, v8, zero8, busy8, done8;
  logic [7:0] a8, b8, y8;
  logic        start16, sub16, ci16, co16, v16, zero16, busy16, done16;
  logic [15:0] a16, b16, y16;

  serial_add_sub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
    .CLK(clk), .RST(rst_n), .START(start8), .SUB(sub8), .CI(ci8), .A(a8), .B(b8),
    .Y(y8), .CO(co8), .V(v8), .ZERO(zero8), .BUSY(busy8), .DONE(done8)
  );

  serial_add_sub #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .CLK(clk), .RST(rst_n), .START(start16), .SUB(sub16), .CI(ci16), .A(a16), .B(b16),
    .Y(y16), .CO(co16), .V(v16), .ZERO(zero16), .BUSY(busy16), .DONE(done16)
  );

  typedef struct packed {
    logic [15:0] y;
    logic        co;
    logic        v;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       ci;
    logic [7:0] y;
    logic       co;
    logic       v;
    logic       zero;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  exp_t q8[$];
  exp_t q16[$];
  logic [7:0] held_y8 = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b,
                                  input logic sub, input logic ci);
    exp_t       e;
    logic [7:0] bo;
    logic [8:0] full;
    bo     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bo} + {8'd0, sub ? ~ci : ci};
    e.y    = {8'd0, full[7:0]};
    e.co   = full[8];
    e.v    = (a[7] == bo[7]) && (full[7] != a[7]);
    e.zero = (full[7:0] == 8'd0);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut8_unexpected_done: got DONE=1 expected no DONE at %0t", $time);
      end else begin
        e = q8.pop_front();
        check("y8", 32'(y8), 32'(e.y));
        check("co8", 32'(co8), 32'(e.co));
        check("v8", 32'(v8), 32'(e.v));
        check("zero8", 32'(zero8), 32'(e.zero));
        held_y8 = e.y[7:0];
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done16) begin
      if (q16.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut16_unexpected_done: got DONE=1 expected no DONE at %0t", $time);
      end else begin
        e = q16.pop_front();
        check("y16", 32'(y16), 32'(e.y));
        check("co16", 32'(co16), 32'(e.co));
        check("v16", 32'(v16), 32'(e.v));
        check("zero16", 32'(zero16), 32'(e.zero));
      end
    end
  end

  // One 8-bit operation; optionally re-asserts START with A=0 at a given BUSY cycle.
  task automatic op8(input vec_t v, input int glitch_at);
    int nb;
    @(negedge clk);
    a8 = v.a; b8 = v.b; sub8 = v.sub; ci8 = v.ci; start8 = 1'b1;
    q8.push_back('{y: {8'd0, v.y}, co: v.co, v: v.v, zero: v.zero});
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); ci8 = 1'($urandom);
    nb = 0;
    while (busy8 && nb < 40) begin
      nb++;
      check("y8_held_in_run", 32'(y8), 32'(held_y8));
      if (nb == glitch_at) begin
        start8 = 1'b1; a8 = 8'h00; sub8 = 1'b0;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    check("busy8_cycles", 32'(nb), 32'd8);
    check("done8_after_busy", 32'(done8), 32'd1);
    @(negedge clk);
    check("done8_one_cycle", 32'(done8), 32'd0);
    check("busy8_idle", 32'(busy8), 32'd0);
  endtask

  vec_t tbl[8];

  initial begin
    int   ndone, nbusy;
    int   dcyc[3];
    vec_t rv;
    exp_t re;

    tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'h7F, 8'h7F, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};

    start8 = 0; sub8 = 0; ci8 = 0; a8 = 0; b8 = 0;
    start16 = 0; sub16 = 0; ci16 = 0; a16 = 0; b16 = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check("rst_y8", 32'(y8), 32'd0);
    check("rst_zero8", 32'(zero8), 32'd1);
    check("rst_co8", 32'(co8), 32'd0);
    check("rst_v8", 32'(v8), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_zero16", 32'(zero16), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) op8(tbl[i], (i == 3) ? 3 : 0);

    for (int i = 0; i < 6; i++) begin
      rv.a = 8'($urandom); rv.b = 8'($urandom);
      rv.sub = 1'($urandom); rv.ci = 1'($urandom);
      re = model8(rv.a, rv.b, rv.sub, rv.ci);
      rv.y = re.y[7:0]; rv.co = re.co; rv.v = re.v; rv.zero = re.zero;
      op8(rv, 0);
    end

    // Reset in the middle of an operation: no DONE, flags back to reset values.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; ci8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("busy8_before_reset", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_y8", 32'(y8), 32'd0);
    check("abort_co8", 32'(co8), 32'd0);
    check("abort_v8", 32'(v8), 32'd0);
    check("abort_zero8", 32'(zero8), 32'd1);
    check("abort_busy8", 32'(busy8), 32'd0);
    check("abort_done8", 32'(done8), 32'd0);
    held_y8 = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("no_done_after_abort", 32'(q8.size()), 32'd0);
    op8(tbl[1], 0);

    // 16-bit, 4 bits per cycle, START held high for three back-to-back operations.
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'hEDCC; sub16 = 1'b0; ci16 = 1'b0; start16 = 1'b1;
    q16.push_back('{y: 16'h0000, co: 1'b1, v: 1'b0, zero: 1'b1});
    ndone = 0; nbusy = 0; dcyc = '{0, 0, 0};
    for (int cyc = 1; cyc <= 30 && ndone < 3; cyc++) begin
      @(negedge clk);
      if (busy16) nbusy++;
      if (cyc == 1) begin
        a16 = 16'h0001; b16 = 16'h0002;
        q16.push_back('{y: 16'h0003, co: 1'b0, v: 1'b0, zero: 1'b0});
      end
      if (done16) begin
        dcyc[ndone] = cyc;
        ndone++;
        if (ndone == 3) start16 = 1'b0;
      end else if (ndone == 1 && cyc == dcyc[0] + 1) begin
        a16 = 16'hFFFF; b16 = 16'h0001; sub16 = 1'b1; ci16 = 1'b0;
        q16.push_back('{y: 16'hFFFE, co: 1'b1, v: 1'b0, zero: 1'b0});
      end
    end
    start16 = 1'b0;
    check("done16_count", 32'(ndone), 32'd3);
    check("done16_latency", 32'(dcyc[0]), 32'd5);
    check("done16_period_1", 32'(dcyc[1] - dcyc[0]), 32'd5);
    check("done16_period_2", 32'(dcyc[2] - dcyc[1]), 32'd5);
    check("busy16_cycles", 32'(nbusy), 32'd12);
    @(negedge clk);
    check("done16_idle", 32'(done16), 32'd0);
    check("busy16_idle", 32'(busy16), 32'd0);
    check("q16_drained", 32'(q16.size()), 32'd0);
    check("q8_drained", 32'(q8.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand and result width in bits (>= 2).
REQ-002 SHALL provide parameter BITS_PER_CYCLE, default 1, bits processed per clock (>= 1, divides WIDTH).
REQ-003 SHALL use one clock and an asynchronous active-low reset: CLK clocks all state; RST asserted (0) resets immediately, independent of CLK.
REQ-004 SHALL have these ports:
- CLK    input   1      clock, rising edge
- RST    input   1      asynchronous active-low reset
- START  input   1      request an operation; sampled on rising CLK
- SUB    input   1      0 = add, 1 = subtract; sampled with START
- CI     input   1      carry-in (add) / borrow-in (subtract); sampled with START
- A      input   WIDTH  operand A; sampled with START
- B      input   WIDTH  operand B; sampled with START
- Y      output  WIDTH  result
- CO     output  1      carry-out (add) / no-borrow (subtract)
- V      output  1      two's-complement signed overflow
- ZERO   output  1      1 when Y == 0
- BUSY   output  1      operation in progress
- DONE   output  1      one-cycle completion pulse

Function
REQ-005 SHALL define STEPS = WIDTH / BITS_PER_CYCLE; a parameter set with WIDTH mod BITS_PER_CYCLE != 0 or BITS_PER_CYCLE > WIDTH SHALL fail elaboration.
REQ-006 SHALL implement a three-state FSM: IDLE, RUN and DONE_ST.
REQ-007 In IDLE or DONE_ST with START=1 at a rising edge, SHALL capture A, B^{SUB replicated}, SUB and initial carry (CI when SUB=0, ~CI when SUB=1), clear the step counter and enter RUN.
REQ-008 SHALL compute A + B + CI when SUB=0 and A - B - CI when SUB=1, i.e. A + ~B + ~CI, modulo 2^WIDTH.
REQ-009 Each RUN edge SHALL add the next BITS_PER_CYCLE bits, LSB group first, through a ripple chain of 1-bit full-adder cells, and SHALL carry the chain carry-out into the next step.
REQ-010 On the STEPS-th RUN edge SHALL load Y, CO (final carry), V (carry into MSB XOR carry out of MSB) and ZERO, and SHALL enter DONE_ST.
REQ-011 BUSY SHALL be 1 exactly while in RUN (STEPS cycles); DONE SHALL be 1 exactly while in DONE_ST (one cycle).
REQ-012 DONE_ST without START SHALL return to IDLE; with START SHALL accept the new operation per REQ-007 and DONE SHALL still pulse that cycle.
REQ-013 START, A, B, SUB and CI SHALL be ignored while BUSY=1; the operation in flight SHALL be unaffected.
REQ-014 Y, CO, V and ZERO SHALL hold the last completed result through IDLE and through any following RUN, and SHALL change only at the REQ-010 edge.
REQ-015 Latency SHALL be fixed: the START-accept edge plus STEPS edges; DONE SHALL be high in the cycle after the STEPS-th edge following acceptance.
REQ-016 With BITS_PER_CYCLE = WIDTH, STEPS = 1: BUSY SHALL be high for one cycle and DONE SHALL follow.

Reset
REQ-017 RST=0 SHALL force IDLE and set Y=0, CO=0, V=0, ZERO=1, BUSY=0 and DONE=0, and SHALL clear all internal operand, carry and counter registers.
REQ-018 Reset during RUN SHALL abort the operation with no DONE pulse and no result update; START SHALL be honoured from the first rising edge after RST deasserts.

Verification
REQ-019 WIDTH=8, K=1, after reset: ZERO=1, Y=0; then A=8'hFF, B=8'h01, CI=0, SUB=0, START pulse -> BUSY high 8 cycles, then DONE pulse with Y=8'h00, CO=1, V=0, ZERO=1.
REQ-020 WIDTH=8, K=1: A=8'h80, B=8'h01, SUB=1, CI=0 -> Y=8'h7F, CO=1, V=1, ZERO=0; then A=8'h7F, B=8'h01, SUB=0 -> Y=8'h80, CO=0, V=1.
REQ-021 WIDTH=8, K=1: A=8'h05, B=8'h03, SUB=1, CI=1 -> Y=8'h01, CO=1, V=0; START with A=8'h00 asserted at cycle 3 of BUSY is ignored; result unchanged, BUSY length still 8.
REQ-022 WIDTH=16, K=4: A=16'h1234, B=16'hEDCC, SUB=0, CI=0 -> BUSY 4 cycles, Y=16'h0000, CO=1, ZERO=1; START held high in DONE_ST -> back-to-back operation, DONE pulse every 5 cycles.
REQ-023 WIDTH=8, K=1: RST pulse low at BUSY cycle 5 -> Y=0, CO=0, V=0, ZERO=1, BUSY=0 immediately; no DONE; next START completes normally 8 cycles later.
